// File: rtl/huffman_pkg.sv
// huffman_pkg
// Shared definitions for the Huffman encoder/decoder pair: symbol and
// length widths, default code/FIFO sizes and the decoder FSM state encoding.
// No ports; import with "import huffman_pkg::*;".
package huffman_pkg;

  localparam int SYM_W          = 4;   // symbol index width
  localparam int NUM_SYM        = 16;  // code-table entries
  localparam int LEN_W          = 4;   // code-length field width
  localparam int CODE_MAX_DEF   = 8;   // default longest codeword
  localparam int FIFO_DEPTH_DEF = 4;   // default symbol buffer depth

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_FAULT  = 2'd2;

endpackage

// File: rtl/huffman_sym_fifo.sv
// huffman_sym_fifo
// Small synchronous FIFO buffering decoded symbols.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write request and data
//   pop               : read request (ignored while empty)
//   pop_data          : head entry, forced to zero while empty
//   full, empty       : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is dropped here and the caller reports the overflow.
module huffman_sym_fifo
  import huffman_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = SYM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // When full, the simultaneous pop frees the slot the push writes into.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Zero the head when empty so stale entries never leak out.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder
// Serial Huffman decoder with a writable 16-entry code table and a small
// output symbol FIFO.
// Ports:
//   Clk, Reset            : clock, synchronous active-high reset
//   Dec_en                : decode enable (IDLE <-> DECODE, leaves FAULT)
//   Bit_in, Bit_valid     : serial codeword bits, MSB first
//   Tbl_wr, Tbl_sym,
//   Tbl_len, Tbl_code     : code-table write port (len 0 = unused entry)
//   Sym_rd                : pop the FIFO head
//   Sym_out, Sym_valid    : FIFO head symbol and non-empty flag
//   Err                   : high while in FAULT (no code matched CODE_MAX bits)
//   Ovf                   : sticky, a decoded symbol was dropped on a full FIFO
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int CODE_MAX   = CODE_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Dec_en,
  input  logic                Bit_in,
  input  logic                Bit_valid,
  input  logic                Tbl_wr,
  input  logic [SYM_W-1:0]    Tbl_sym,
  input  logic [LEN_W-1:0]    Tbl_len,
  input  logic [CODE_MAX-1:0] Tbl_code,
  input  logic                Sym_rd,
  output logic [SYM_W-1:0]    Sym_out,
  output logic                Sym_valid,
  output logic                Err,
  output logic                Ovf
);

  state_t              state_q, state_d;
  logic [CODE_MAX-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [LEN_W-1:0]    tbl_len_q  [NUM_SYM];
  logic [LEN_W-1:0]    tbl_len_d  [NUM_SYM];
  logic [CODE_MAX-1:0] tbl_code_q [NUM_SYM];
  logic [CODE_MAX-1:0] tbl_code_d [NUM_SYM];

  logic                accept;
  logic [CODE_MAX-1:0] acc_n;
  logic [LEN_W-1:0]    cnt_n;
  logic [CODE_MAX-1:0] code_mask;
  logic                hit;
  logic [SYM_W-1:0]    hit_sym;
  logic                push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;

  assign accept = (state_q == ST_DECODE) & Bit_valid;
  assign acc_n  = {acc_q[CODE_MAX-2:0], Bit_in};
  assign cnt_n  = cnt_q + 1'b1;

  // Keeps the low cnt_n bits; a shift by CODE_MAX yields an all-ones mask.
  assign code_mask = ~({CODE_MAX{1'b1}} << cnt_n);

  // Matching reads the registered table, so a same-cycle write is not seen.
  // Scanning downward lets the lowest matching index overwrite the result.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    for (int s = NUM_SYM - 1; s >= 0; s--) begin
      if ((tbl_len_q[s] == cnt_n) &&
          (((tbl_code_q[s] ^ acc_n) & code_mask) == '0)) begin
        hit     = 1'b1;
        hit_sym = SYM_W'(s);
      end
    end
  end

  // Any exit from DECODE discards the partial codeword.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Dec_en) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (accept) begin
          if (hit) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else if (cnt_n == LEN_W'(CODE_MAX)) begin
            state_d = ST_FAULT;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = acc_n;
            cnt_d = cnt_n;
          end
        end
        if (!Dec_en && (state_d == ST_DECODE)) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (!Dec_en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Table writes are allowed in every state.
  always_comb begin
    tbl_len_d  = tbl_len_q;
    tbl_code_d = tbl_code_q;
    if (Tbl_wr) begin
      tbl_len_d[Tbl_sym]  = Tbl_len;
      tbl_code_d[Tbl_sym] = Tbl_code;
    end
  end

  // A push lost to a full FIFO latches Ovf until reset.
  assign fifo_pop = Sym_rd & ~fifo_empty;

  always_comb begin
    ovf_d = ovf_q | (push & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int s = 0; s < NUM_SYM; s++) begin
        tbl_len_q[s] <= '0;
      end
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      tbl_len_q <= tbl_len_d;
    end
  end

  // Codewords are only meaningful with a non-zero length, so no reset.
  always_ff @(posedge Clk) begin
    tbl_code_q <= tbl_code_d;
  end

  huffman_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SYM_W)
  ) u_fifo (
    .clk       (Clk),
    .reset     (Reset),
    .push      (push),
    .push_data (hit_sym),
    .pop       (fifo_pop),
    .pop_data  (Sym_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign Sym_valid = ~fifo_empty;
  assign Err       = (state_q == ST_FAULT);
  assign Ovf       = ovf_q;

endmodule
